// File: rtl/convking_fifo_pkg.sv
// Shared types and helpers for the ConvKing single-clock width-converting FIFO.
// SYNC_WIDTH_FIFO_FWFT_EN selects first-word-fall-through reads in the users of this package.
package convking_fifo_pkg;

  localparam int MAX_DATA_W = 1024;

  typedef logic [MAX_DATA_W-1:0] wide_t;

  typedef struct packed {
    logic wr_full;
    logic almost_full;
    logic rd_empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = fifo_flags_t'{
    wr_full:      1'b0,
    almost_full:  1'b0,
    rd_empty:     1'b1,
    almost_empty: 1'b1
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int min_width(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int units_ratio(input int width, input int unit_w);
    return width / unit_w;
  endfunction

  // Places one unit into lane `lane` of a wide word; lane 0 is the least significant.
  function automatic wide_t pack_lane(input wide_t word, input wide_t unit,
                                      input int lane, input int unit_w);
    wide_t mask;
    mask = (wide_t'(1'b1) << unit_w) - wide_t'(1'b1);
    return (word & ~(mask << (lane * unit_w))) | ((unit & mask) << (lane * unit_w));
  endfunction

endpackage

// File: rtl/sync_width_fifo_ram.sv
// Unit-addressed storage for sync_width_fifo: WR_UNITS-wide write port, RD_UNITS-wide read port.
// SYNC_WIDTH_FIFO_FWFT_EN makes the read port asynchronous; otherwise it is registered.
module sync_width_fifo_ram
  import convking_fifo_pkg::*;
#(
  parameter int c_UNIT_W   = 16,
  parameter int c_WR_UNITS = 4,
  parameter int c_RD_UNITS = 1,
  parameter int c_ADDR_W   = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [c_ADDR_W-1:0]              wr_addr,
  input  logic [c_WR_UNITS*c_UNIT_W-1:0]   wr_data,
  input  logic                             rd_en,
  input  logic [c_ADDR_W-1:0]              rd_addr,
  output logic [c_RD_UNITS*c_UNIT_W-1:0]   rd_data
);

  localparam int DEPTH = 1 << c_ADDR_W;
  localparam int RD_W  = c_RD_UNITS * c_UNIT_W;

  logic [c_UNIT_W-1:0] mem [DEPTH];
  wide_t               rd_word_s;
  logic                unused_hi_s;

  // Scatter the write word into consecutive units, lane 0 first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int lane = 0; lane < c_WR_UNITS; lane++) begin
        mem[wr_addr + c_ADDR_W'(lane)] <= wr_data[lane*c_UNIT_W +: c_UNIT_W];
      end
    end
  end

  // Gather consecutive units into one read word, oldest unit in the low lane.
  always_comb begin
    rd_word_s = '0;
    for (int lane = 0; lane < c_RD_UNITS; lane++) begin
      rd_word_s = pack_lane(rd_word_s, wide_t'(mem[rd_addr + c_ADDR_W'(lane)]), lane, c_UNIT_W);
    end
  end

  assign unused_hi_s = ^rd_word_s[MAX_DATA_W-1:RD_W];

`ifdef SYNC_WIDTH_FIFO_FWFT_EN
  logic unused_ctrl_s;

  assign rd_data       = rd_word_s[RD_W-1:0];
  assign unused_ctrl_s = rst ^ rd_en;
`else
  logic [RD_W-1:0] rd_data_q;
  logic [RD_W-1:0] rd_data_d;

  // Output register only moves on an accepted read and holds otherwise.
  always_comb begin
    if (rd_en) begin
      rd_data_d = rd_word_s[RD_W-1:0];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_width_fifo.sv
// Single-clock width-converting FIFO: unit pointers, water level, flags and error pulses.
// Define SYNC_WIDTH_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_width_fifo
  import convking_fifo_pkg::*;
#(
  parameter int c_WR_DATA_WIDTH    = 64,
  parameter int c_RD_DATA_WIDTH    = 16,
  parameter int c_DEPTH_WIDTH      = 7,
  parameter int c_ALMOST_FULL_NUM  = 120,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [c_WR_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_en,
  output logic                       wr_full,
  output logic                       almost_full,
  output logic                       wr_ovf,
  output logic [c_RD_DATA_WIDTH-1:0] rd_data,
  input  logic                       rd_en,
  output logic                       rd_empty,
  output logic                       almost_empty,
  output logic                       rd_udf,
  output logic [c_DEPTH_WIDTH:0]     water_level
);

  localparam int UNIT_W   = min_width(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH);
  localparam int WR_UNITS = units_ratio(c_WR_DATA_WIDTH, UNIT_W);
  localparam int RD_UNITS = units_ratio(c_RD_DATA_WIDTH, UNIT_W);
  localparam int CAP      = 32'd1 << c_DEPTH_WIDTH;
  localparam int PW       = c_DEPTH_WIDTH + 1;

  localparam logic [PW-1:0] WR_STEP    = PW'(WR_UNITS);
  localparam logic [PW-1:0] RD_STEP    = PW'(RD_UNITS);
  localparam logic [PW-1:0] FULL_LIMIT = PW'(CAP - WR_UNITS);
  localparam logic [PW-1:0] AF_NUM     = PW'(c_ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_NUM     = PW'(c_ALMOST_EMPTY_NUM);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  fifo_flags_t   flags_q, flags_d;
  logic          wr_ovf_q, wr_ovf_d;
  logic          rd_udf_q, rd_udf_d;
  logic          wr_accept_s;
  logic          rd_accept_s;

  // Acceptance uses the registered flags; the next flags come from the next level.
  always_comb begin
    wr_accept_s = wr_en & ~flags_q.wr_full;
    rd_accept_s = rd_en & ~flags_q.rd_empty;

    if (wr_accept_s) begin
      wptr_d = wptr_q + WR_STEP;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_accept_s) begin
      rptr_d = rptr_q + RD_STEP;
    end else begin
      rptr_d = rptr_q;
    end

    level_d = wptr_d - rptr_d;

    flags_d.wr_full      = level_d > FULL_LIMIT;
    flags_d.almost_full  = level_d >= AF_NUM;
    flags_d.rd_empty     = level_d < RD_STEP;
    flags_d.almost_empty = level_d <= AE_NUM;

    wr_ovf_d = wr_en & flags_q.wr_full;
    rd_udf_d = rd_en & flags_q.rd_empty;
  end

  // Pointer, level, flag and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      flags_q  <= FLAGS_RESET;
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      flags_q  <= flags_d;
      wr_ovf_q <= wr_ovf_d;
      rd_udf_q <= rd_udf_d;
    end
  end

  sync_width_fifo_ram #(
    .c_UNIT_W   (UNIT_W),
    .c_WR_UNITS (WR_UNITS),
    .c_RD_UNITS (RD_UNITS),
    .c_ADDR_W   (c_DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept_s),
    .wr_addr (wptr_q[c_DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept_s),
    .rd_addr (rptr_q[c_DEPTH_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  assign wr_full      = flags_q.wr_full;
  assign almost_full  = flags_q.almost_full;
  assign wr_ovf       = wr_ovf_q;
  assign rd_empty     = flags_q.rd_empty;
  assign almost_empty = flags_q.almost_empty;
  assign rd_udf       = rd_udf_q;
  assign water_level  = level_q;

endmodule

// File: tb/tb_sync_width_fifo.sv
// Scoreboard bench for sync_width_fifo: randomized 64->16 traffic against a unit-queue model,
// plus a directed 16->64 instance. Honors SYNC_WIDTH_FIFO_FWFT_EN for the read-data checks.
module tb_sync_width_fifo;

  localparam int CAP = 128;
  localparam int WRU = 4;
  localparam int RDU = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wr_data;
  logic        wr_en, rd_en;
  logic        wr_full, almost_full, wr_ovf, rd_empty, almost_empty, rd_udf;
  logic [15:0] rd_data;
  logic [7:0]  water_level;

  logic        b_rst;
  logic [15:0] b_wr_data;
  logic        b_wr_en, b_rd_en;
  logic        b_wr_full, b_almost_full, b_wr_ovf, b_rd_empty, b_almost_empty, b_rd_udf;
  logic [63:0] b_rd_data;
  logic [7:0]  b_water_level;
  bit          b_done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_rd = 16'h0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_width_fifo dut_a (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .almost_full(almost_full), .wr_ovf(wr_ovf), .rd_data(rd_data), .rd_en(rd_en),
    .rd_empty(rd_empty), .almost_empty(almost_empty), .rd_udf(rd_udf),
    .water_level(water_level)
  );

  sync_width_fifo #(.c_WR_DATA_WIDTH(16), .c_RD_DATA_WIDTH(64)) dut_b (
    .clk(clk), .rst(b_rst), .wr_data(b_wr_data), .wr_en(b_wr_en), .wr_full(b_wr_full),
    .almost_full(b_almost_full), .wr_ovf(b_wr_ovf), .rd_data(b_rd_data), .rd_en(b_rd_en),
    .rd_empty(b_rd_empty), .almost_empty(b_almost_empty), .rd_udf(b_rd_udf),
    .water_level(b_water_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit w, input logic [63:0] d, input bit r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the FIFO is a queue of 16-bit units, oldest unit first.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd  = 16'h0;
    end else begin
      bit wa;
      bit ra;
      wa = wr_en && (mq.size() <= CAP - WRU);
      ra = rd_en && (mq.size() >= RDU);
      m_ovf = wr_en && !wa;
      m_udf = rd_en && !ra;
      if (ra) begin
        m_rd = mq.pop_front();
        exp_q.push_back(m_rd);
      end
      if (wa) begin
        for (int i = 0; i < WRU; i++) mq.push_back(wr_data[16*i +: 16]);
      end
    end
  end

  // Monitor: compares status every cycle and read data whenever the DUT accepts a read.
  initial forever begin
    bit fire;
    @(posedge clk);
    fire = rd_en && !rd_empty && !rst;
    @(negedge clk);
    check("level", water_level, mq.size());
    check("level_le_cap", water_level <= CAP, 1'b1);
    check("wr_full", wr_full, mq.size() > CAP - WRU);
    check("almost_full", almost_full, mq.size() >= 120);
    check("rd_empty", rd_empty, mq.size() < RDU);
    check("almost_empty", almost_empty, mq.size() <= 4);
    check("wr_ovf", wr_ovf, m_ovf);
    check("rd_udf", rd_udf, m_udf);
`ifdef SYNC_WIDTH_FIFO_FWFT_EN
    if (mq.size() >= RDU) check("fwft_head", rd_data, mq[0]);
`else
    check("rd_hold", rd_data, m_rd);
    if (fire) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got read %0h expected no read at %0t", rd_data, $time);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
`endif
  end

  // Directed 16->64 packing sequence on the second instance.
  initial begin
    logic [15:0] vals [3];
    vals[0] = 16'hAAAA;
    vals[1] = 16'hBBBB;
    vals[2] = 16'hCCCC;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = 16'h0;
    repeat (2) @(posedge clk);
    #1 b_rst = 1'b0;
    check("b_rst_empty", b_rd_empty, 1'b1);
    for (int i = 0; i < 3; i++) begin
      b_wr_en = 1'b1; b_wr_data = vals[i];
      @(posedge clk); #1;
      check("b_partial_empty", b_rd_empty, 1'b1);
    end
    b_wr_data = 16'hDDDD;
    @(posedge clk); #1;
    b_wr_en = 1'b0;
    check("b_ready", b_rd_empty, 1'b0);
    check("b_level4", b_water_level, 8'd4);
`ifdef SYNC_WIDTH_FIFO_FWFT_EN
    check("b_word", b_rd_data, 64'hDDDD_CCCC_BBBB_AAAA);
`endif
    b_rd_en = 1'b1;
    @(posedge clk); #1;
    b_rd_en = 1'b0;
`ifndef SYNC_WIDTH_FIFO_FWFT_EN
    check("b_word", b_rd_data, 64'hDDDD_CCCC_BBBB_AAAA);
`endif
    check("b_after_empty", b_rd_empty, 1'b1);
    check("b_after_level", b_water_level, 8'd0);
    b_done = 1'b1;
  end

  initial begin
    logic [63:0] last_fill;
    logic [15:0] post_rst [4];
    int wpct;
    int rpct;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 64'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_level", water_level, 8'd0);
    check("rst_flags", {wr_full, almost_full, rd_empty, almost_empty}, 4'b0011);
`ifndef SYNC_WIDTH_FIFO_FWFT_EN
    check("rst_rd_data", rd_data, 16'h0);
`endif

    // 64->16 lane order, then drain to empty.
    step(1'b1, 64'h4444_3333_2222_1111, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1);
    check("lanes_empty", rd_empty, 1'b1);

    // Fill, overflow, drain, underflow.
    last_fill = 64'h0;
    for (int i = 0; i < 32; i++) begin
      last_fill = {$urandom, $urandom};
      step(1'b1, last_fill, 1'b0);
    end
    check("fill_level", water_level, 8'd128);
    check("fill_full", wr_full, 1'b1);
    step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("ovf_pulse", wr_ovf, 1'b1);
    check("ovf_level", water_level, 8'd128);
    step(1'b0, 64'h0, 1'b0);
    check("ovf_once", wr_ovf, 1'b0);
    for (int i = 0; i < 128; i++) step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("udf_pulse", rd_udf, 1'b1);
    check("udf_level", water_level, 8'd0);
`ifndef SYNC_WIDTH_FIFO_FWFT_EN
    check("udf_hold", rd_data, last_fill[63:48]);
`endif
    step(1'b0, 64'h0, 1'b0);
    check("udf_once", rd_udf, 1'b0);

    // Simultaneous read and write at level 4.
    step(1'b1, 64'h0D0C_0B0A_0908_0706, 1'b0);
    check("sim_level4", water_level, 8'd4);
    step(1'b1, 64'h1D1C_1B1A_1918_1716, 1'b1);
    check("sim_level7", water_level, 8'd7);

    // Randomized traffic in phases that swing the level between full and empty.
    for (int ph = 0; ph < 4; ph++) begin
      wpct = (ph % 2 == 0) ? 45 : 12;
      rpct = (ph % 2 == 0) ? 55 : 90;
      for (int i = 0; i < 160; i++) begin
        step($urandom_range(0, 99) < wpct, {$urandom, $urandom}, $urandom_range(0, 99) < rpct);
      end
    end

    // Reset in the middle of operation at level 50.
    for (int i = 0; i < 140; i++) step(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("pre_rst_level", water_level, 8'd50);
    rst = 1'b1;
    step(1'b0, 64'h0, 1'b0);
    rst = 1'b0;
    check("mid_rst_level", water_level, 8'd0);
    check("mid_rst_flags", {wr_full, almost_full, rd_empty, almost_empty}, 4'b0011);
    post_rst[0] = 16'hCDEF; post_rst[1] = 16'h89AB;
    post_rst[2] = 16'h4567; post_rst[3] = 16'h0123;
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifdef SYNC_WIDTH_FIFO_FWFT_EN
      check("post_rst_word", rd_data, post_rst[i]);
      step(1'b0, 64'h0, 1'b1);
`else
      step(1'b0, 64'h0, 1'b1);
      check("post_rst_word", rd_data, post_rst[i]);
`endif
    end
    step(1'b0, 64'h0, 1'b0);

    for (int i = 0; i < 100 && !b_done; i++) @(posedge clk);
    if (!b_done) begin
      n_checks++;
      $display("FAIL b_timeout: got not done expected done");
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
